// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs loads/stores on a req/ack data bus, stalls upstream while busy, registers MEM/WB.
// Optional build macro MEM_ALIGN_CHECK_EN turns misaligned word accesses into a squashed, flagged no-op.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] walu,
    output logic [31:0] wmo,
    output logic [4:0]  wrn,
    output logic        mem_timeout,
    output logic        mem_misalign
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   tcnt;
    logic            access;
    logic            misalign;
    logic            tmax;
    logic            start;
    logic            abandon;
    logic            capture;
    logic            stall_c;
    logic            cap_wwreg;
    logic            cap_wm2reg;
    logic [31:0]     cap_wmo;

    assign access = mm2reg | mwmem;
    assign tmax   = (tcnt == TW'(TIMEOUT - 1));

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (state == IDLE) && access && (malu[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        stall_c    = 1'b0;
        start      = 1'b0;
        abandon    = 1'b0;
        capture    = 1'b0;
        cap_wwreg  = mwreg;
        cap_wm2reg = mm2reg;
        cap_wmo    = 32'd0;
        case (state)
            IDLE: begin
                if (misalign) begin
                    capture    = 1'b1;
                    cap_wwreg  = 1'b0;
                    cap_wm2reg = 1'b0;
                end else if (access) begin
                    stall_c  = 1'b1;
                    start    = 1'b1;
                    state_nx = WAIT;
                end else begin
                    capture = 1'b1;
                end
            end
            WAIT: begin
                if (bus_ack) begin
                    capture  = 1'b1;
                    cap_wmo  = mm2reg ? bus_rdata : 32'd0;
                    state_nx = IDLE;
                end else if (tmax) begin
                    abandon   = 1'b1;
                    capture   = 1'b1;
                    cap_wwreg = 1'b0;
                    state_nx  = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
        endcase
    end

    // Gate with reset so the pipeline is never held while the stage is being reset.
    assign stall = stall_c & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_nx;
            if (start)
                tcnt <= '0;
            else if (state == WAIT && !tmax)
                tcnt <= tcnt + 1'b1;
        end
    end

    // Bus request register: address/data/we only load at request start and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
        end else if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= mwmem;
            bus_addr  <= malu;
            bus_wdata <= mb;
        end else if (state == WAIT && state_nx == IDLE) begin
            bus_req <= 1'b0;
        end
    end

    // MEM/WB register: a bubble clears the controls and leaves the data fields untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wwreg        <= 1'b0;
            wm2reg       <= 1'b0;
            walu         <= 32'd0;
            wmo          <= 32'd0;
            wrn          <= 5'd0;
            mem_timeout  <= 1'b0;
            mem_misalign <= 1'b0;
        end else begin
            mem_timeout  <= abandon;
            mem_misalign <= misalign;
            if (capture) begin
                wwreg  <= cap_wwreg;
                wm2reg <= cap_wm2reg;
                walu   <= malu;
                wmo    <= cap_wmo;
                wrn    <= mrn;
            end else begin
                wwreg  <= 1'b0;
                wm2reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (TIMEOUT = 16); misalign case built with MEM_ALIGN_CHECK_EN.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] malu, mb, bus_addr, bus_wdata, bus_rdata, walu, wmo;
    logic [4:0]  mrn, wrn;
    logic        mwreg, mm2reg, mwmem, bus_req, bus_we, bus_ack, stall;
    logic        wwreg, wm2reg, mem_timeout, mem_misalign;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .malu(malu), .mb(mb), .mrn(mrn),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall(stall),
        .wwreg(wwreg), .wm2reg(wm2reg), .walu(walu), .wmo(wmo), .wrn(wrn),
        .mem_timeout(mem_timeout), .mem_misalign(mem_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                         input logic wreg, input logic m2reg, input logic wmem);
        malu   = alu;
        mb     = b;
        mrn    = rn;
        mwreg  = wreg;
        mm2reg = m2reg;
        mwmem  = wmem;
    endtask

    task automatic nop;
        drive(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    int st;
    int pulses;

    initial begin
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        drive(32'h100, 32'd0, 5'd1, 1'b1, 1'b1, 1'b0);
        #12;
        check("rst_stall", stall, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_wwreg", wwreg, 0);
        check("rst_walu", walu, 0);
        check("rst_wrn", wrn, 0);
        check("rst_timeout", mem_timeout, 0);
        check("rst_misalign", mem_misalign, 0);
        nop();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU op passes straight through
        drive(32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        #1 check("alu_stall", stall, 0);
        tick();
        check("alu_wwreg", wwreg, 1);
        check("alu_walu", walu, 32'h0000_1234);
        check("alu_wrn", wrn, 5);
        check("alu_bus_req", bus_req, 0);

        // load, ack on first WAIT cycle
        drive(32'h100, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        #1 check("ld_stall_idle", stall, 1);
        tick();
        check("ld_bus_req", bus_req, 1);
        check("ld_bus_we", bus_we, 0);
        check("ld_bus_addr", bus_addr, 32'h100);
        check("ld_bubble_wwreg", wwreg, 0);
        check("ld_bubble_walu_hold", walu, 32'h0000_1234);
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        #1 check("ld_stall_ack", stall, 0);
        tick();
        bus_ack = 1'b0;
        check("ld_wmo", wmo, 32'hCAFE_F00D);
        check("ld_wm2reg", wm2reg, 1);
        check("ld_wwreg", wwreg, 1);
        check("ld_wrn", wrn, 7);
        check("ld_walu", walu, 32'h100);
        check("ld_bus_req_low", bus_req, 0);
        nop();

        // stray ack in IDLE is ignored
        bus_ack   = 1'b1;
        bus_rdata = 32'h1234_5678;
        tick();
        bus_ack = 1'b0;
        check("idle_ack_req", bus_req, 0);
        check("idle_ack_wmo", wmo, 0);
        check("idle_ack_wwreg", wwreg, 0);

        // store, ack on the fourth WAIT cycle
        bus_rdata = 32'hDEAD_BEEF;
        drive(32'h200, 32'h55AA_55AA, 5'd0, 1'b0, 1'b0, 1'b1);
        st = 0;
        for (int c = 0; c < 5; c++) begin
            bus_ack = (c == 4);
            #1;
            if (stall) st++;
            check("st_wwreg_before", wwreg, 0);
            if (c > 0) begin
                check("st_bus_req", bus_req, 1);
                check("st_bus_we", bus_we, 1);
                check("st_bus_addr", bus_addr, 32'h200);
                check("st_bus_wdata", bus_wdata, 32'h55AA_55AA);
            end
            tick();
        end
        bus_ack = 1'b0;
        check("st_stall_cycles", st, 4);
        check("st_wwreg_after", wwreg, 0);
        check("st_wmo_zero", wmo, 0);
        check("st_walu", walu, 32'h200);
        check("st_bus_req_low", bus_req, 0);
        check("st_addr_hold", bus_addr, 32'h200);
        nop();

        // load with no ack: timeout
        drive(32'h300, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0);
        st = 0;
        pulses = 0;
        for (int c = 0; c < 17; c++) begin
            #1;
            if (stall) st++;
            tick();
            if (c < 16 && mem_timeout) pulses++;
        end
        check("to_stall_cycles", st, 16);
        check("to_early_pulse", pulses, 0);
        check("to_pulse", mem_timeout, 1);
        check("to_wwreg", wwreg, 0);
        check("to_wmo", wmo, 0);
        check("to_walu", walu, 32'h300);
        check("to_bus_req", bus_req, 0);
        nop();
        tick();
        check("to_pulse_end", mem_timeout, 0);

        // asynchronous reset in the middle of a WAIT
        drive(32'h400, 32'd0, 5'd2, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        check("mr_bus_req_pre", bus_req, 1);
        #2 rst_n = 1'b0;
        nop();
        #1;
        check("mr_bus_req", bus_req, 0);
        check("mr_stall", stall, 0);
        check("mr_bus_addr", bus_addr, 0);
        check("mr_walu", walu, 0);
        check("mr_wrn", wrn, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // load after reset, then a back-to-back load
        drive(32'h500, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0);
        #1 check("bb_stall1", stall, 1);
        tick();
        check("bb_req1", bus_req, 1);
        bus_ack   = 1'b1;
        bus_rdata = 32'h0BAD_CAFE;
        tick();
        bus_ack = 1'b0;
        check("bb_wmo1", wmo, 32'h0BAD_CAFE);
        check("bb_wrn1", wrn, 3);
        check("bb_req_gap", bus_req, 0);
        drive(32'h504, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0);
        #1 check("bb_stall2", stall, 1);
        tick();
        check("bb_req2", bus_req, 1);
        check("bb_addr2", bus_addr, 32'h504);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_2222;
        tick();
        bus_ack = 1'b0;
        check("bb_wmo2", wmo, 32'h1111_2222);
        nop();

`ifdef MEM_ALIGN_CHECK_EN
        drive(32'h102, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0);
        #1 check("ma_stall", stall, 0);
        tick();
        check("ma_bus_req", bus_req, 0);
        check("ma_pulse", mem_misalign, 1);
        check("ma_wwreg", wwreg, 0);
        check("ma_wm2reg", wm2reg, 0);
        check("ma_wmo", wmo, 0);
        nop();
        tick();
        check("ma_pulse_end", mem_misalign, 0);
`else
        tick();
        check("no_misalign", mem_misalign, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

MEM-stage controller of the pipelined MIPS CPU: consumes the EXE/MEM pipeline register outputs, runs load/store accesses on a request/acknowledge data-memory bus, stalls the upstream pipeline while an access is outstanding, and registers the MEM/WB stage outputs. It sits between the EXE/MEM register and the write-back stage.

## Interface
- TIMEOUT, 16: maximum WAIT cycles without `bus_ack` before the access is abandoned (≥2).
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- malu  in  32  ALU result / effective address
- mb  in  32  store data
- mrn  in  5  destination register number
- mwreg, mm2reg, mwmem  in  1 each  register write, load (memory-to-register), store
- bus_req  out  1  registered access request
- bus_we  out  1  registered write enable (1 = store)
- bus_addr  out  32  registered word address
- bus_wdata  out  32  registered store data
- bus_ack  in  1  memory completion; `bus_rdata` valid in the same cycle
- bus_rdata  in  32  load data
- stall  out  1  combinational; 1 = hold PC, IF/ID, ID/EXE, EXE/MEM
- wwreg, wm2reg  out  1 each  MEM/WB control
- walu, wmo  out  32 each  MEM/WB ALU result, memory data
- wrn  out  5  MEM/WB destination register
- mem_timeout  out  1  one-cycle pulse on abandoned access
- mem_misalign  out  1  one-cycle pulse on misaligned access (0 when feature compiled out)

## Operation
- access = mm2reg | mwmem; a store takes priority if both are set (bus_we = 1).
- FSM states IDLE, WAIT. Counter `tcnt` sized to hold TIMEOUT-1.
- IDLE, access = 0: no stall; MEM/WB captures the stage.
- IDLE, access = 1: stall = 1. At the edge, go to WAIT; bus_req = 1, bus_we = mwmem, bus_addr = malu, bus_wdata = mb, tcnt = 0. MEM/WB captures a bubble.
- WAIT, bus_ack = 1: stall = 0. At the edge, go to IDLE; bus_req = 0; MEM/WB captures the stage with wmo = bus_rdata if mm2reg, else 0.
- WAIT, bus_ack = 0, tcnt < TIMEOUT-1: stall = 1; tcnt increments; bubble into MEM/WB.
- WAIT, bus_ack = 0, tcnt = TIMEOUT-1: stall = 0. At the edge, go to IDLE; bus_req = 0; mem_timeout = 1 for one cycle; MEM/WB captures the stage with wwreg = 0 and wmo = 0.
- MEM/WB capture: wwreg = mwreg, wm2reg = mm2reg, walu = malu, wrn = mrn, wmo as above.
- Bubble: wwreg = 0 and wm2reg = 0; walu, wrn, wmo hold their values.
- bus_addr, bus_we, bus_wdata are stable while bus_req = 1. They hold their last values after bus_req falls.
- A bus_ack seen in IDLE is ignored.

## Timing
- Reset (asynchronous, at any time including mid-access): state IDLE, tcnt 0, and every output 0 (bus_req, bus_we, bus_addr, bus_wdata, wwreg, wm2reg, walu, wmo, wrn, mem_timeout, mem_misalign); stall evaluates to 0.
- Non-memory instruction: 1 cycle, no stall.
- Memory access with ack on first WAIT cycle: 2 cycles, 1 stall cycle. Each extra wait cycle adds one stall cycle.
- Timeout access: TIMEOUT+1 cycles total.
- Back-to-back accesses: the next access always spends one IDLE cycle before bus_req rises. bus_req therefore drops for at least one cycle between accesses.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Condition: access = 1 in IDLE with malu[1:0] ≠ 0.
  - No bus request and no stall.
  - mem_misalign pulses for one cycle after the edge.
  - MEM/WB captures the stage with wwreg = 0, wm2reg = 0, wmo = 0.
- `MEM_ALIGN_CHECK_EN` undefined:
  - No alignment check; bus_addr = malu unchanged.
  - mem_misalign tied 0.

## Test plan
- ALU op, mwreg = 1, malu = 0x0000_1234, mrn = 5 → no stall; next cycle wwreg = 1, walu = 0x0000_1234, wrn = 5, bus_req = 0.
- Load malu = 0x100, bus_ack one cycle after bus_req with rdata = 0xCAFE_F00D → stall high 1 cycle; wmo = 0xCAFE_F00D, wm2reg = 1, wwreg = 1.
- Store malu = 0x200, mb = 0x55AA_55AA, ack delayed 3 cycles → bus_we = 1, address and data stable throughout; stall high 4 cycles; wwreg = 0 before and after.
- Load with no ack, TIMEOUT = 16 → stall high 16 cycles; mem_timeout pulses once; wwreg = 0, wmo = 0; bus_req low afterwards.
- rst_n low during WAIT → bus_req and stall drop immediately; all outputs 0; the next load after reset completes normally.
- With `MEM_ALIGN_CHECK_EN`, load malu = 0x102 → no bus_req, no stall, mem_misalign one pulse, wwreg = 0.
